// File: rtl/uart_bus_arbiter_pkg.sv
// Shared encodings for the two-requester UART bus arbiter: FSM states,
// UART register addresses, abort data and the round-robin pick helper.
package uart_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam logic [1:0] UART_ADDR_DATA = 2'd0;
    localparam logic [1:0] UART_ADDR_IER  = 2'd1;
    localparam logic [1:0] UART_ADDR_IIR  = 2'd2;
    localparam logic [1:0] UART_ADDR_LCR  = 2'd3;

    localparam logic [7:0] ABORT_DATA = 8'hFF;

    typedef struct packed {
        logic       we;
        logic [1:0] addr;
        logic [7:0] data;
    } bus_req_t;

    // Both requesting: the preferred requester wins; otherwise whoever asks.
    function automatic logic rr_pick(input logic stb0, input logic stb1, input logic ptr);
        return (stb0 && stb1) ? ptr : stb1;
    endfunction

endpackage

// File: rtl/uart_arb_timer.sv
// BUS-phase watchdog for the UART arbiter; only built with UART_ARB_TIMEOUT_EN.
// load clears the count, count advances it, expire flags the TIMEOUT-th BUS cycle.
`ifdef UART_ARB_TIMEOUT_EN
module uart_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = count && (cnt_q == LAST);

endmodule
`endif

// File: rtl/uart_bus_arbiter.sv
// Round-robin arbiter sharing one UART register bus between two requesters.
// Optional BUS-phase timeout with error response is enabled by UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m0_stb,
    input  logic       m0_we,
    input  logic [1:0] m0_addr,
    input  logic [7:0] m0_data_in,
    output logic [7:0] m0_data_out,
    output logic       m0_ack,
    output logic       m0_err,
    input  logic       m1_stb,
    input  logic       m1_we,
    input  logic [1:0] m1_addr,
    input  logic [7:0] m1_data_in,
    output logic [7:0] m1_data_out,
    output logic       m1_ack,
    output logic       m1_err,
    output logic       wb_stb,
    output logic       wb_we,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data_in,
    input  logic [7:0] wb_data_out,
    input  logic       wb_ack
);
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("uart_bus_arbiter: TIMEOUT must lie in 2..255");
    end

    arb_state_e state_q, state_d;
    bus_req_t   req_q, req_d;
    logic       ptr_q, ptr_d;
    logic       win_q, win_d;
    logic       wb_stb_q, wb_stb_d;
    logic       m0_ack_q, m0_ack_d;
    logic       m1_ack_q, m1_ack_d;
    logic [7:0] m0_data_q, m0_data_d;
    logic [7:0] m1_data_q, m1_data_d;

    logic       any_stb;
    logic       grant_idx;
    logic       abort;
    logic       finish;
    logic [7:0] rsp_data;

    assign any_stb   = m0_stb || m1_stb;
    assign grant_idx = rr_pick(m0_stb, m1_stb, ptr_q);
    // A real ack beats a coincident expiry: the UART did complete the access.
    assign finish    = (state_q == ST_BUS) && (wb_ack || abort);
    assign rsp_data  = wb_ack ? wb_data_out : ABORT_DATA;

`ifdef UART_ARB_TIMEOUT_EN
    logic m0_err_q, m0_err_d;
    logic m1_err_q, m1_err_d;
    logic tmr_load, tmr_count;

    assign tmr_load  = (state_q == ST_IDLE) && any_stb;
    assign tmr_count = (state_q == ST_BUS);

    uart_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .count (tmr_count),
        .expire(abort)
    );

    always_comb begin
        m0_err_d = 1'b0;
        m1_err_d = 1'b0;
        if (finish && !wb_ack) begin
            m0_err_d = !win_q;
            m1_err_d = win_q;
        end
    end

    assign m0_err = m0_err_q;
    assign m1_err = m1_err_q;
`else
    assign abort  = 1'b0;
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        wb_stb_d  = wb_stb_q;
        m0_ack_d  = 1'b0;
        m1_ack_d  = 1'b0;
        m0_data_d = m0_data_q;
        m1_data_d = m1_data_q;
        case (state_q)
            ST_IDLE: begin
                if (any_stb) begin
                    win_d      = grant_idx;
                    req_d.we   = grant_idx ? m1_we      : m0_we;
                    req_d.addr = grant_idx ? m1_addr    : m0_addr;
                    req_d.data = grant_idx ? m1_data_in : m0_data_in;
                    wb_stb_d   = 1'b1;
                    state_d    = ST_BUS;
                end
            end
            ST_BUS: begin
                if (finish) begin
                    wb_stb_d = 1'b0;
                    ptr_d    = ~win_q;
                    state_d  = ST_DONE;
                    if (win_q) begin
                        m1_ack_d  = 1'b1;
                        m1_data_d = rsp_data;
                    end else begin
                        m0_ack_d  = 1'b1;
                        m0_data_d = rsp_data;
                    end
                end
            end
            // Ack is visible here; skipping the grant stops a requester whose
            // stb has not yet fallen from being served twice.
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d  = ST_IDLE;
                wb_stb_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            wb_stb_q  <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            m0_data_q <= '0;
            m1_data_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            wb_stb_q  <= wb_stb_d;
            m0_ack_q  <= m0_ack_d;
            m1_ack_q  <= m1_ack_d;
            m0_data_q <= m0_data_d;
            m1_data_q <= m1_data_d;
`ifdef UART_ARB_TIMEOUT_EN
            m0_err_q  <= m0_err_d;
            m1_err_q  <= m1_err_d;
`endif
        end
    end

    assign wb_stb      = wb_stb_q;
    assign wb_we       = req_q.we;
    assign wb_addr     = req_q.addr;
    assign wb_data_in  = req_q.data;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_data_out = m0_data_q;
    assign m1_data_out = m1_data_q;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Self-checking bench for uart_bus_arbiter: the bench plays both requesters and
// the UART, and predicts grant order, latency and response data itself.
module tb_uart_bus_arbiter;
    import uart_bus_arbiter_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_stb, m0_we, m0_ack, m0_err;
    logic [1:0] m0_addr;
    logic [7:0] m0_data_in, m0_data_out;
    logic       m1_stb, m1_we, m1_ack, m1_err;
    logic [1:0] m1_addr;
    logic [7:0] m1_data_in, m1_data_out;
    logic       wb_stb, wb_we;
    logic [1:0] wb_addr;
    logic [7:0] wb_data_in, wb_data_out;
    logic       wb_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    uart_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_data_in(m0_data_in),
        .m0_data_out(m0_data_out), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_data_in(m1_data_in),
        .m1_data_out(m1_data_out), .m1_ack(m1_ack), .m1_err(m1_err),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data_in(wb_data_in),
        .wb_data_out(wb_data_out), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    // UART model: acks on BUS cycle uart_wait+1 (never if negative); stray
    // acks outside BUS when requested.
    int         uart_wait = 0;
    logic [7:0] uart_rdata = 8'h00;
    bit         stray = 1'b0;
    int         bus_cyc = 0;
    assign wb_data_out = uart_rdata;

    always @(posedge clk) begin
        #1;
        if (wb_stb) bus_cyc++; else bus_cyc = 0;
        wb_ack = (wb_stb && uart_wait >= 0 && bus_cyc == uart_wait + 1) || (stray && !wb_stb);
    end

    // Bus monitor: transfers started, fields presented, stability, ack pulses.
    int          xfers = 0, unstable = 0, ack_cnt0 = 0, ack_cnt1 = 0;
    logic        prev_stb = 1'b0;
    logic [10:0] last_bus = '0;
    logic [10:0] bus_log[$];

    always @(negedge clk) begin
        if (wb_stb && !prev_stb) begin
            xfers++;
            last_bus = {wb_we, wb_addr, wb_data_in};
            bus_log.push_back(last_bus);
        end else if (wb_stb && ({wb_we, wb_addr, wb_data_in} !== last_bus)) begin
            unstable++;
        end
        prev_stb = wb_stb;
        if (m0_ack) ack_cnt0++;
        if (m1_ack) ack_cnt1++;
    end

    // Requester-side state and per-transaction observations.
    logic       req_we[2];
    logic [1:0] req_addr[2];
    logic [7:0] req_data[2];
    int         obs_lat[2];
    logic [7:0] obs_data[2];
    logic       obs_err[2];
    logic       obs_stb_at_ack[2];
    int         obs_acks[2];
    int         obs_order[$];
    bit         txn_timeout;
    int         txn_acks, txn_xfers;
    int         model_ptr = 0;

    task automatic do_reset();
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_ptr = 0;
    endtask

    task automatic rand_req(input int r);
        req_we[r]   = 1'($urandom_range(0, 1));
        req_addr[r] = 2'($urandom_range(0, 3));
        req_data[r] = 8'($urandom_range(0, 255));
    endtask

    // Raise the selected stbs, drop each one cycle after its ack, then idle.
    task automatic run_txn(input bit use0, input bit use1, input int budget);
        bit acked[2];
        bit pend[2];
        bit done;
        int a_start, x_start;
        obs_order.delete();
        bus_log.delete();
        for (int r = 0; r < 2; r++) begin
            obs_lat[r] = -1; obs_data[r] = 'x; obs_err[r] = 1'b0;
            obs_stb_at_ack[r] = 1'b0; obs_acks[r] = 0; acked[r] = 0; pend[r] = 0;
        end
        a_start = ack_cnt0 + ack_cnt1;
        x_start = xfers;
        m0_we = req_we[0]; m0_addr = req_addr[0]; m0_data_in = req_data[0];
        m1_we = req_we[1]; m1_addr = req_addr[1]; m1_data_in = req_data[1];
        m0_stb = use0;
        m1_stb = use1;
        done = 0;
        for (int cyc = 1; cyc <= budget && !done; cyc++) begin
            @(posedge clk); #1;
            if (pend[0]) begin m0_stb = 1'b0; pend[0] = 0; end
            if (pend[1]) begin m1_stb = 1'b0; pend[1] = 0; end
            @(negedge clk);
            if (m0_ack) begin
                obs_acks[0]++;
                if (!acked[0]) begin
                    acked[0] = 1; pend[0] = 1; obs_lat[0] = cyc; obs_data[0] = m0_data_out;
                    obs_err[0] = m0_err; obs_stb_at_ack[0] = wb_stb; obs_order.push_back(0);
                end
            end
            if (m1_ack) begin
                obs_acks[1]++;
                if (!acked[1]) begin
                    acked[1] = 1; pend[1] = 1; obs_lat[1] = cyc; obs_data[1] = m1_data_out;
                    obs_err[1] = m1_err; obs_stb_at_ack[1] = wb_stb; obs_order.push_back(1);
                end
            end
            done = (acked[0] == use0) && (acked[1] == use1) && !pend[0] && !pend[1];
        end
        txn_timeout = !done;
        repeat (4) @(posedge clk);
        #1;
        m0_stb = 1'b0;
        m1_stb = 1'b0;
        txn_acks  = ack_cnt0 + ack_cnt1 - a_start;
        txn_xfers = xfers - x_start;
    endtask

    task automatic test_reset();
        logic [31:0] outs;
        do_reset();
        @(negedge clk);
        outs = {wb_stb, wb_we, wb_addr, wb_data_in, m0_ack, m0_err, m0_data_out,
                m1_ack, m1_err, m1_data_out};
        checks++;
        if (outs !== 32'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 00000000", outs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        req_we[0] = 1'b1; req_addr[0] = UART_ADDR_DATA; req_data[0] = 8'd65;
        uart_wait = 0; uart_rdata = 8'h3C;
        run_txn(1, 0, 20);
        checks++;
        if (obs_lat[0] !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", obs_lat[0]); end
        checks++;
        if (bus_log[0] !== {1'b1, UART_ADDR_DATA, 8'd65}) begin
            errors++; $display("FAIL write_bus_fields: got %h want %h", bus_log[0], {1'b1, UART_ADDR_DATA, 8'd65});
        end
        checks++;
        if ({obs_err[0], obs_data[0]} !== {1'b0, 8'h3C}) begin
            errors++; $display("FAIL write_response: got err %b data %h want err 0 data 3c", obs_err[0], obs_data[0]);
        end
        checks++;
        if (obs_acks[1] !== 0 || m1_data_out !== 8'h00) begin
            errors++; $display("FAIL write_m1_quiet: got acks %0d data %h want 0 00", obs_acks[1], m1_data_out);
        end
        model_ptr = 1;
        rand_req(0); rand_req(1);
        run_txn(1, 1, 40);
        checks++;
        if (obs_order.size() !== 2 || obs_order[0] !== model_ptr) begin
            errors++; $display("FAIL ptr_after_write: got first %0d want %0d", obs_order[0], model_ptr);
        end
        model_ptr = 1 - obs_order[$];
    endtask

    task automatic test_round_robin();
        int exp0, exp1;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            rand_req(0); rand_req(1);
            uart_wait = $urandom_range(0, 3);
            uart_rdata = 8'($urandom_range(0, 255));
            run_txn(1, 1, 60);
            exp0 = model_ptr;
            exp1 = 1 - model_ptr;
            model_ptr = 1 - exp1;
            checks++;
            if (obs_order.size() !== 2 || obs_order[0] !== exp0 || obs_order[1] !== exp1) begin
                errors++; $display("FAIL rr_order pair %0d: got %0d,%0d want %0d,%0d", p, obs_order[0], obs_order[1], exp0, exp1);
            end
            checks++;
            if (obs_data[0] !== uart_rdata || obs_data[1] !== uart_rdata) begin
                errors++; $display("FAIL rr_data pair %0d: got %h,%h want %h", p, obs_data[0], obs_data[1], uart_rdata);
            end
            checks++;
            if (bus_log.size() !== 2 || bus_log[1] !== {req_we[exp1], req_addr[exp1], req_data[exp1]}) begin
                errors++; $display("FAIL rr_bus_fields pair %0d: got %h want %h", p, bus_log[1], {req_we[exp1], req_addr[exp1], req_data[exp1]});
            end
        end
    endtask

    task automatic test_read_wait();
        do_reset();
        req_we[1] = 1'b0; req_addr[1] = UART_ADDR_IIR; req_data[1] = 8'($urandom_range(0, 255));
        uart_wait = 3; uart_rdata = 8'h5A;
        run_txn(0, 1, 40);
        model_ptr = 0;
        checks++;
        if (obs_lat[1] !== 5 || obs_data[1] !== 8'h5A) begin
            errors++; $display("FAIL read_wait: got lat %0d data %h want 5 5a", obs_lat[1], obs_data[1]);
        end
        checks++;
        if (bus_log[0][10:8] !== {1'b0, UART_ADDR_IIR}) begin
            errors++; $display("FAIL read_bus_fields: got %h want %h", bus_log[0][10:8], {1'b0, UART_ADDR_IIR});
        end
        checks++;
        if (obs_acks[0] !== 0 || {m0_ack, m0_err, m0_data_out} !== 10'd0) begin
            errors++; $display("FAIL read_m0_quiet: got acks %0d outs %h want 0 000", obs_acks[0], {m0_ack, m0_err, m0_data_out});
        end
    endtask

    task automatic test_stray_ack();
        int bad = 0;
        int a0;
        stray = 1'b1;
        a0 = ack_cnt0 + ack_cnt1;
        repeat (5) begin
            @(negedge clk);
            if (wb_stb !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || ack_cnt0 + ack_cnt1 !== a0) begin
            errors++; $display("FAIL stray_idle: got stb cycles %0d acks %0d want 0 0", bad, ack_cnt0 + ack_cnt1 - a0);
        end
        @(posedge clk); #1;
        rand_req(0);
        uart_wait = 2; uart_rdata = 8'($urandom_range(0, 255));
        run_txn(1, 0, 30);
        stray = 1'b0;
        model_ptr = 1;
        checks++;
        if (obs_lat[0] !== 4 || obs_data[0] !== uart_rdata || txn_acks !== 1 || txn_xfers !== 1) begin
            errors++; $display("FAIL stray_txn: got lat %0d data %h acks %0d xfers %0d want 4 %h 1 1",
                               obs_lat[0], obs_data[0], txn_acks, txn_xfers, uart_rdata);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            int r;
            r = i % 2;
            rand_req(r);
            uart_wait = $urandom_range(0, 2);
            run_txn(r == 0, r == 1, 30);
            model_ptr = 1 - r;
            checks++;
            if (txn_xfers !== 1 || txn_acks !== 1 || obs_acks[r] !== 1) begin
                errors++; $display("FAIL done_guard %0d: got xfers %0d acks %0d want 1 1", i, txn_xfers, txn_acks);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        logic [31:0] outs;
        rand_req(0);
        m0_we = req_we[0]; m0_addr = req_addr[0]; m0_data_in = req_data[0];
        uart_wait = -1;
        a0 = ack_cnt0 + ack_cnt1;
        m0_stb = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++;
        if (wb_stb !== 1'b1) begin errors++; $display("FAIL mid_bus_stb: got %b want 1", wb_stb); end
        reset = 1'b1;
        m0_stb = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_ptr = 0;
        @(negedge clk);
        outs = {wb_stb, wb_we, wb_addr, wb_data_in, m0_ack, m0_err, m0_data_out,
                m1_ack, m1_err, m1_data_out};
        checks++;
        if (outs !== 32'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h want 00000000", outs); end
        repeat (3) @(negedge clk);
        checks++;
        if (ack_cnt0 + ack_cnt1 !== a0) begin errors++; $display("FAIL mid_reset_acks: got %0d want 0", ack_cnt0 + ack_cnt1 - a0); end
        @(posedge clk); #1;
        rand_req(1);
        uart_wait = 0; uart_rdata = 8'($urandom_range(0, 255));
        run_txn(0, 1, 20);
        model_ptr = 0;
        checks++;
        if (obs_lat[1] !== 2 || obs_data[1] !== uart_rdata || obs_err[1] !== 1'b0) begin
            errors++; $display("FAIL post_reset_txn: got lat %0d data %h err %b want 2 %h 0", obs_lat[1], obs_data[1], obs_err[1], uart_rdata);
        end
    endtask

    task automatic test_timeout();
        rand_req(0);
        uart_wait = -1;
`ifdef UART_ARB_TIMEOUT_EN
        run_txn(1, 0, 40);
        model_ptr = 1;
        checks++;
        if (obs_lat[0] !== TO + 1 || obs_err[0] !== 1'b1 || obs_data[0] !== ABORT_DATA || obs_stb_at_ack[0] !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: got lat %0d err %b data %h stb %b want %0d 1 ff 0",
                               obs_lat[0], obs_err[0], obs_data[0], obs_stb_at_ack[0], TO + 1);
        end
        uart_wait = 0;
        rand_req(1);
        run_txn(0, 1, 20);
        model_ptr = 0;
        checks++;
        if (obs_err[1] !== 1'b0 || obs_lat[1] !== 2) begin
            errors++; $display("FAIL after_timeout_txn: got err %b lat %0d want 0 2", obs_err[1], obs_lat[1]);
        end
`else
        run_txn(1, 0, 3 * TO);
        checks++;
        if (!txn_timeout || wb_stb !== 1'b1 || m0_err !== 1'b0 || obs_acks[0] !== 0) begin
            errors++; $display("FAIL no_timeout_wait: got done %b stb %b err %b acks %0d want 0 1 0 0",
                               !txn_timeout, wb_stb, m0_err, obs_acks[0]);
        end
        uart_wait = 0;
        do_reset();
`endif
    endtask

    task automatic test_random();
        int exp_order[$];
        bit u0, u1;
        int mode;
        for (int it = 0; it < 16; it++) begin
            mode = $urandom_range(1, 3);
            u0 = mode[0];
            u1 = mode[1];
            rand_req(0); rand_req(1);
            uart_wait = $urandom_range(0, 4);
            uart_rdata = 8'($urandom_range(0, 255));
            exp_order.delete();
            if (u0 && u1) begin
                exp_order.push_back(model_ptr);
                exp_order.push_back(1 - model_ptr);
            end else begin
                exp_order.push_back(u1 ? 1 : 0);
            end
            model_ptr = 1 - exp_order[$];
            run_txn(u0, u1, 80);
            checks++;
            if (txn_timeout || obs_order.size() !== exp_order.size() || txn_xfers !== exp_order.size()) begin
                errors++; $display("FAIL rand_count %0d: got acks %0d xfers %0d want %0d", it, obs_order.size(), txn_xfers, exp_order.size());
            end else begin
                foreach (exp_order[k]) begin
                    int w;
                    w = exp_order[k];
                    checks++;
                    if (obs_order[k] !== w || obs_data[w] !== uart_rdata || obs_err[w] !== 1'b0 ||
                        bus_log[k] !== {req_we[w], req_addr[w], req_data[w]}) begin
                        errors++; $display("FAIL rand_txn %0d.%0d: got req %0d data %h bus %h want req %0d data %h bus %h",
                                           it, k, obs_order[k], obs_data[w], bus_log[k], w, uart_rdata, {req_we[w], req_addr[w], req_data[w]});
                    end
                end
            end
        end
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL bus_stability: got %0d changes want 0", unstable); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_data_in = '0;
        m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_data_in = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_read_wait();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
